// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the writeback register file and its scoreboard.
package wb_regfile_pkg;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int NUM_REGS    = 32;
    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 5;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [1:0]        pend_t;

    localparam pend_t PEND_MAX = 2'd3;

endpackage

// File: rtl/wb_regfile_if.sv
// Bus bundle between the pipeline (MEM/WB writeback, ID reads/issue) and wb_regfile.
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    logic [1:0] WB;
    data_t      read_data;
    data_t      ALU_result;
    addr_t      RegDst_address;
    addr_t      rs_addr;
    addr_t      rt_addr;
    data_t      rs_data;
    data_t      rt_data;
    logic       issue_valid;
    addr_t      issue_rd;
    logic       flush;
    logic       busy_rs;
    logic       busy_rt;
    data_t      wb_data;

    modport master (
        output WB, read_data, ALU_result, RegDst_address, rs_addr, rt_addr,
               issue_valid, issue_rd, flush,
        input  rs_data, rt_data, busy_rs, busy_rt, wb_data
    );

    modport slave (
        input  WB, read_data, ALU_result, RegDst_address, rs_addr, rt_addr,
               issue_valid, issue_rd, flush,
        output rs_data, rt_data, busy_rs, busy_rt, wb_data
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Per-register 2-bit pending-write counters; reports whether a source register
// still has an unretired write in flight.
module wb_scoreboard
    import wb_regfile_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  issue_valid,
    input  addr_t issue_rd,
    input  logic  retire,
    input  addr_t retire_rd,
    input  logic  flush,
    input  addr_t rs_addr,
    input  addr_t rt_addr,
    output logic  busy_rs,
    output logic  busy_rt
);

    pend_t               cnt [1:NUM_REGS-1];
    logic [NUM_REGS-1:0] inc_hit;
    logic [NUM_REGS-1:0] dec_hit;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        if (issue_valid && issue_rd != '0) inc_hit[issue_rd]  = 1'b1;
        if (retire && retire_rd != '0)     dec_hit[retire_rd] = 1'b1;
    end

    // NOTE: sequential state uses <= so all counters update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NUM_REGS; r++) cnt[r] <= '0;
        end else if (flush) begin
            for (int r = 1; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc_hit[r] && !dec_hit[r] && cnt[r] != PEND_MAX)
                    cnt[r] <= cnt[r] + pend_t'(1);
                else if (dec_hit[r] && !inc_hit[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - pend_t'(1);
            end
        end
    end

    // A write retiring now with nothing else pending no longer counts as busy.
    function automatic logic busy_of(addr_t a);
        if (a == '0) return 1'b0;
        return (cnt[a] != '0) && !(dec_hit[a] && cnt[a] == pend_t'(1) && !inc_hit[a]);
    endfunction

    always_comb begin
        busy_rs = busy_of(rs_addr);
        busy_rt = busy_of(rt_addr);
    end

endmodule

// File: rtl/wb_regfile.sv
// 32x32 register file with writeback mux, same-cycle read bypass and pending-write scoreboard.
// Optional WB_REGFILE_DBG_EN adds a bypassed debug read port and a retired-write counter.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    wb_regfile_if.slave  bus
`ifdef WB_REGFILE_DBG_EN
    ,
    input  addr_t        dbg_addr,
    output data_t        dbg_data,
    output logic [31:0]  wb_count
`endif
);

    data_t regs [1:NUM_REGS-1];
    logic  retire;

    assign bus.wb_data = bus.WB[WB_MEMTOREG] ? bus.read_data : bus.ALU_result;
    assign retire      = bus.WB[WB_REGWRITE] && (bus.RegDst_address != '0);

    // NOTE: the storage array is cleared by reset because every register must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NUM_REGS; r++) regs[r] <= '0;
        end else if (retire) begin
            regs[bus.RegDst_address] <= bus.wb_data;
        end
    end

    // Reads are forced to 0 while reset is held, and bypass the retiring write.
    function automatic data_t read_port(addr_t a);
        if (!rst_n || a == '0) return '0;
        if (retire && a == bus.RegDst_address) return bus.wb_data;
        return regs[a];
    endfunction

    always_comb begin
        bus.rs_data = read_port(bus.rs_addr);
        bus.rt_data = read_port(bus.rt_addr);
    end

    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .retire      (retire),
        .retire_rd   (bus.RegDst_address),
        .flush       (bus.flush),
        .rs_addr     (bus.rs_addr),
        .rt_addr     (bus.rt_addr),
        .busy_rs     (bus.busy_rs),
        .busy_rt     (bus.busy_rt)
    );

`ifdef WB_REGFILE_DBG_EN
    always_comb dbg_data = read_port(dbg_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      wb_count <= '0;
        else if (retire) wb_count <= wb_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized bench for wb_regfile against an array-based reference model,
// with directed sequences pinning bypass, register 0, saturation, flush and async reset.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_regfile_if bus ();

`ifdef WB_REGFILE_DBG_EN
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] wb_count;
`endif

    wb_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef WB_REGFILE_DBG_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wb_count (wb_count)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    logic [31:0] m_wbcount;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_wb();
        return bus.WB[0] ? bus.read_data : bus.ALU_result;
    endfunction

    function automatic bit exp_retire();
        return bus.WB[1] && bus.RegDst_address != 5'd0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'd0;
        if (exp_retire() && bus.RegDst_address == a) return exp_wb();
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        bit issue_here, retire_here;
        if (!rst_n || a == 5'd0) return 1'b0;
        issue_here  = bus.issue_valid && bus.issue_rd == a;
        retire_here = exp_retire() && bus.RegDst_address == a;
        return (m_cnt[a] != 0) && !(retire_here && m_cnt[a] == 1 && !issue_here);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 32'd0;
            m_cnt[r]  = 0;
        end
        m_wbcount = 32'd0;
    endtask

    task automatic update_model();
        int n;
        if (!rst_n) return;
        for (int r = 1; r < 32; r++) begin
            n = m_cnt[r];
            if (bus.issue_valid && bus.issue_rd == r) n = n + 1;
            if (exp_retire() && bus.RegDst_address == r) n = n - 1;
            if (n > 3) n = 3;
            if (n < 0) n = 0;
            m_cnt[r] = bus.flush ? 0 : n;
        end
        if (exp_retire()) begin
            m_regs[bus.RegDst_address] = exp_wb();
            m_wbcount = m_wbcount + 32'd1;
        end
    endtask

    task automatic compare_model();
        check("wb_data", bus.wb_data, exp_wb());
        check("rs_data", bus.rs_data, exp_read(bus.rs_addr));
        check("rt_data", bus.rt_data, exp_read(bus.rt_addr));
        check("busy_rs", 32'(bus.busy_rs), 32'(exp_busy(bus.rs_addr)));
        check("busy_rt", 32'(bus.busy_rt), 32'(exp_busy(bus.rt_addr)));
`ifdef WB_REGFILE_DBG_EN
        check("dbg_data", dbg_data, exp_read(dbg_addr));
        check("wb_count", wb_count, m_wbcount);
`endif
    endtask

    // Called just after a negedge with inputs set; compares, then commits one clock.
    task automatic step();
        #1;
        compare_model();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.WB             = 2'b00;
        bus.read_data      = 32'd0;
        bus.ALU_result     = 32'd0;
        bus.RegDst_address = 5'd0;
        bus.issue_valid    = 1'b0;
        bus.issue_rd       = 5'd0;
        bus.flush          = 1'b0;
    endtask

    // Reset asserted between edges; one posedge passes under reset with inputs live.
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_model();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [4:0] raddr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        bus.rs_addr = 5'd0;
        bus.rt_addr = 5'd0;
`ifdef WB_REGFILE_DBG_EN
        dbg_addr = 5'd0;
`endif
        model_reset();
        repeat (2) @(negedge clk);

        bus.rs_addr = 5'd5;
        bus.rt_addr = 5'd31;
        #1;
        check("rst_rs_data", bus.rs_data, 32'd0);
        check("rst_rt_data", bus.rt_data, 32'd0);
        check("rst_busy_rs", 32'(bus.busy_rs), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_rs_data", bus.rs_data, 32'd0);
        check("post_rst_busy_rt", 32'(bus.busy_rt), 32'd0);
        step();

        // Same-cycle bypass, then the value persists in storage.
        bus.WB = 2'b10; bus.ALU_result = 32'h1234; bus.RegDst_address = 5'd8; bus.rs_addr = 5'd8;
        #1;
        check("bypass_rs8", bus.rs_data, 32'h1234);
        step();
        idle(); bus.rs_addr = 5'd8;
        #1;
        check("stored_rs8", bus.rs_data, 32'h1234);
        step();

        // Writes to register 0 are dropped; wb_data still follows MemtoReg.
        bus.WB = 2'b11; bus.read_data = 32'hDEADBEEF; bus.ALU_result = 32'h1; bus.RegDst_address = 5'd0;
        bus.rs_addr = 5'd0; bus.rt_addr = 5'd0;
        #1;
        check("wb_data_load", bus.wb_data, 32'hDEADBEEF);
        check("r0_bypass", bus.rs_data, 32'd0);
        step();
        idle();
        #1;
        check("r0_after", bus.rt_data, 32'd0);
        step();

        // Saturation at 3, drain by retires, and issue+retire at count 1.
        idle(); bus.rs_addr = 5'd4; bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
        repeat (4) step();
        idle();
        #1;
        check("busy_sat", 32'(bus.busy_rs), 32'd1);
        step();
        bus.WB = 2'b10; bus.RegDst_address = 5'd4; bus.ALU_result = 32'h44;
        step();
        step();
        #1;
        check("busy_last_retire", 32'(bus.busy_rs), 32'd0);
        step();
        idle();
        #1;
        check("busy_drained", 32'(bus.busy_rs), 32'd0);
        step();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
        step();
        bus.WB = 2'b10; bus.RegDst_address = 5'd4; bus.ALU_result = 32'h45;
        #1;
        check("busy_iss_ret", 32'(bus.busy_rs), 32'd1);
        step();
        idle();
        #1;
        check("busy_iss_ret_after", 32'(bus.busy_rs), 32'd1);
        step();

        // Flush clears counters but the retiring write still lands.
        idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        step();
        bus.issue_rd = 5'd10;
        step();
        idle(); bus.flush = 1'b1; bus.WB = 2'b10; bus.RegDst_address = 5'd9; bus.ALU_result = 32'hAAAA5555;
        step();
        idle(); bus.rs_addr = 5'd9; bus.rt_addr = 5'd10;
        #1;
        check("flush_busy9", 32'(bus.busy_rs), 32'd0);
        check("flush_busy10", 32'(bus.busy_rt), 32'd0);
        check("flush_r9", bus.rs_data, 32'hAAAA5555);
        step();

        // Async reset between edges clears storage immediately.
        bus.WB = 2'b10; bus.RegDst_address = 5'd2; bus.ALU_result = 32'h22;
        step();
        bus.RegDst_address = 5'd3; bus.ALU_result = 32'h33;
        step();
        idle(); bus.rs_addr = 5'd2; bus.rt_addr = 5'd3;
        #1;
        check("pre_rst_r2", bus.rs_data, 32'h22);
        check("pre_rst_r3", bus.rt_data, 32'h33);
        rst_n = 1'b0;
        #1;
        check("async_rst_r2", bus.rs_data, 32'd0);
        check("async_rst_r3", bus.rt_data, 32'd0);
`ifdef WB_REGFILE_DBG_EN
        check("async_rst_wb_count", wb_count, 32'd0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 3000; i++) begin
            bus.WB             = 2'($urandom_range(0, 3));
            bus.read_data      = $urandom;
            bus.ALU_result     = $urandom;
            bus.RegDst_address = raddr();
            bus.rs_addr        = raddr();
            bus.rt_addr        = raddr();
            bus.issue_valid    = ($urandom_range(0, 1) == 1);
            bus.issue_rd       = raddr();
            bus.flush          = ($urandom_range(0, 19) == 0);
`ifdef WB_REGFILE_DBG_EN
            dbg_addr           = raddr();
`endif
            if ($urandom_range(0, 299) == 0) async_reset();
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on posedge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 WB  input  2  writeback control from MEM/WB: bit1 RegWrite, bit0 MemtoReg.
REQ-004 read_data  input  32  load data from MEM/WB.
REQ-005 ALU_result  input  32  ALU result from MEM/WB.
REQ-006 RegDst_address  input  5  destination register from MEM/WB.
REQ-007 rs_addr, rt_addr  input  5 each  ID-stage read addresses.
REQ-008 rs_data, rt_data  output  32 each  ID-stage read data, combinational.
REQ-009 issue_valid  input  1  ID issues an instruction that will write a register.
REQ-010 issue_rd  input  5  destination of the issued instruction.
REQ-011 flush  input  1  discard all in-flight scoreboard entries.
REQ-012 busy_rs, busy_rt  output  1 each  source register has a pending (unretired) write.
REQ-013 wb_data  output  32  selected writeback data, combinational.

Function
REQ-014 wb_data SHALL equal read_data when WB[0]=1, else ALU_result.
REQ-015 On posedge with WB[1]=1 and RegDst_address!=0, register[RegDst_address] SHALL take wb_data.
REQ-016 Register 0 SHALL read 0 always; writes to it SHALL be ignored.
REQ-017 Read ports SHALL bypass: if WB[1]=1, RegDst_address!=0 and equals the read address, output wb_data in the same cycle.
REQ-018 Scoreboard: one 2-bit pending counter per register 1..31.
REQ-019 issue_valid=1 with issue_rd!=0 SHALL increment count[issue_rd]; a retiring write (REQ-015 condition) SHALL decrement count[RegDst_address].
REQ-020 Simultaneous increment and decrement of the same register SHALL leave the count unchanged.
REQ-021 Increment at count 3 SHALL saturate at 3; decrement at count 0 SHALL remain 0.
REQ-022 busy_rs/busy_rt SHALL be 1 iff count of the addressed register is nonzero, excluding a register being retired this cycle with count 1 and no simultaneous issue to it; address 0 SHALL give 0.
REQ-023 flush=1 SHALL clear all counters at next posedge, overriding issue and retire; the register write itself SHALL still occur.

Reset
REQ-024 rst_n=0 SHALL clear all 32 registers and all counters immediately, independent of clk.
REQ-025 During reset, rs_data, rt_data, busy_rs and busy_rt SHALL be 0; wb_data stays combinational.
REQ-026 Reset deassertion mid-operation SHALL not cause any write until the next posedge with rst_n=1.

Configuration
REQ-027 Macro WB_REGFILE_DBG_EN: when defined, add a dbg_addr input (5), a dbg_data output (32, bypassed like REQ-017) and a wb_count output (32) counting retired writes, wrapping 0xFFFFFFFF->0 and cleared by reset.
REQ-028 Without WB_REGFILE_DBG_EN, these ports and the counter SHALL NOT exist.

Structure
REQ-029 Shared package SHALL hold WB bit indices (WB_REGWRITE=1, WB_MEMTOREG=0), register count 32, data width 32 and address width 5.
REQ-030 The scoreboard SHALL be a sub-module named wb_scoreboard; the storage array and bypass stay in wb_regfile.

Verification
REQ-031 Reset then read rs=5, rt=31 -> rs_data=0, rt_data=0, busy 0.
REQ-032 WB=2'b10, ALU_result=0x1234, RegDst=8, rs=8 same cycle -> rs_data=0x1234 (bypass); next cycle still 0x1234.
REQ-033 WB=2'b11, read_data=0xDEADBEEF, ALU_result=0x1, RegDst=0 -> register 0 reads 0, wb_data=0xDEADBEEF.
REQ-034 Issue rd=4 four times -> count saturates at 3, busy_rs=1 for rs=4; three retires to 4 -> busy 0; issue+retire of 4 in one cycle at count 1 -> busy stays 1.
REQ-035 Issue rd=9, rd=10, then flush with retire to 9 -> both counts 0, register 9 written.
REQ-036 Assert rst_n=0 between clock edges after writes to 2 and 3 -> both read 0 immediately; (DBG) wb_count=0.
